fpu_mul_iter: RTL and testbench
===============================

Name: fpu_mul_iter

Overview:
Parametrised iterative shift-add unsigned multiplier for FPU mantissas. It generalises the fixed single-bit mul_* sequencer to any operand width, and it retires STEP_BITS multiplier bits per iteration. It sits under the arithmetic FSM (arith_mul_st / arith_mul_done_st) and produces the full double-width mantissa product. Normalisation and exponent handling stay in the caller.

Parameters:
WIDTH, 24, operand width in bits (mantissa including hidden bit); must be ≥ 2.
STEP_BITS, 1, multiplier bits consumed per iteration; legal values 1, 2, 4; must divide WIDTH (elaboration error otherwise).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
start_i  in  1  request; sampled only in IDLE.
a_i  in  WIDTH  multiplicand; captured on accepted start.
b_i  in  WIDTH  multiplier; captured on accepted start.
ack_i  in  1  caller consumed the result; sampled only in RESULT_VALID.
busy_o  out  1  high whenever state ≠ IDLE (registered).
valid_o  out  1  high only in RESULT_VALID (registered).
product_o  out  2*WIDTH  a*b, exact and unsigned; holds its last value until the next RESULT_SET.

Behaviour:
- Reset (rst_n=0 at an edge, any state including mid-operation):
  - state→IDLE; busy_o=0, valid_o=0, product_o=0.
  - Internal accumulator, shifted operands and counter all cleared.
  - No partial result is ever emitted.
- Internal registers:
  - mcand: 2*WIDTH bits.
  - mplier: WIDTH bits.
  - acc: 2*WIDTH bits.
  - cnt: holds 0..WIDTH/STEP_BITS.
- States and transitions:
  - IDLE: if start_i, load mcand={0,a_i}, mplier=b_i, acc=0, cnt=N=WIDTH/STEP_BITS; go to START.
  - START: one setup cycle; go to ADD.
  - ADD: acc += mcand * mplier[STEP_BITS-1:0], computed modulo 2^(2*WIDTH); true overflow is impossible. Go to SHIFT.
  - SHIFT: mcand <<= STEP_BITS, mplier >>= STEP_BITS (logical), cnt−1. If the new cnt is 0 go to RESULT_SET, else go to ADD.
  - RESULT_SET: product_o <= acc; go to RESULT_VALID.
  - RESULT_VALID: valid_o=1; stay until ack_i=1, then go to IDLE.
- Latency:
  - valid_o rises 2N+2 cycles after the edge that accepts start_i.
  - Example: WIDTH=24, STEP_BITS=1 gives 50 cycles.
- Handshake:
  - valid_o and product_o stay stable while waiting for ack; there is no timeout.
  - start_i is ignored while busy_o=1; it is not queued.
  - ack_i is ignored outside RESULT_VALID.
  - ack_i and start_i both high in RESULT_VALID: the ack is taken and the block returns to IDLE. That start is not captured; the caller must keep start_i high into the IDLE cycle.
  - Earliest back-to-back accept is one cycle after the ack edge.
- Boundaries:
  - a or b = 0: product 0, still full latency.
  - a = b = 2^WIDTH−1: product (2^WIDTH−1)^2, exact.
  - a_i/b_i changes after capture have no effect.

Optional Feature:
FPU_MUL_EARLY_EXIT_EN.
- Defined: in SHIFT, if the shifted mplier is 0 the block goes to RESULT_SET regardless of cnt.
  - Latency becomes 2k+2, where k = max(1, ceil(bitlen(b)/STEP_BITS)).
  - Result is identical to the full run.
- Undefined: fixed 2N+2 latency, as above.

Test Plan:
1. W=24, S=1, a=0xC00000, b=0xA00000 → valid_o high exactly 50 cycles after accept; product_o=0x780000000000; busy_o high throughout.
2. W=24, S=1, a=b=0xFFFFFF → product_o=0xFFFFFE000001; a=0 case → product_o=0 at cycle 50.
3. W=8, S=4, a=0xFF, b=0x0F → product_o=0x0EF1, valid at cycle 6.
4. Handshake: hold ack_i low 10 cycles → valid_o and product_o stable; start_i pulsed mid-operation is ignored; ack+start together → IDLE, no new operation.
5. Reset: rst_n=0 at cycle 20 of an operation → next cycle busy_o=0, valid_o=0, product_o=0; a new start gives the correct result.
6. With FPU_MUL_EARLY_EXIT_EN, W=24, S=1, a=0x800000, b=0x000003 → product_o=0x1800000, valid at cycle 6. Without the macro → same product at cycle 50.

Source files
------------

// File: rtl/fpu_mul_iter.sv
// Iterative shift-add unsigned multiplier producing the full 2*WIDTH mantissa product.
// Optional macro FPU_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module fpu_mul_iter #(
  parameter int WIDTH     = 24,
  parameter int STEP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 ack_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int N  = WIDTH / STEP_BITS;
  localparam int CW = $clog2(N + 1);

  if (WIDTH < 2 || (STEP_BITS != 1 && STEP_BITS != 2 && STEP_BITS != 4) ||
      (WIDTH % STEP_BITS) != 0) begin : g_bad_params
    $error("fpu_mul_iter: illegal WIDTH/STEP_BITS combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADD, S_SHIFT, S_RESULT_SET, S_RESULT_VALID
  } state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;

  logic [WIDTH-1:0]     mplier_shifted;
  logic [2*WIDTH-1:0]   step_digit;

  assign mplier_shifted = mplier_q >> STEP_BITS;
  assign step_digit     = {{(2*WIDTH-STEP_BITS){1'b0}}, mplier_q[STEP_BITS-1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (start_i) state_d = S_START;
      S_START:        state_d = S_ADD;
      S_ADD:          state_d = S_SHIFT;
      S_SHIFT: begin
`ifdef FPU_MUL_EARLY_EXIT_EN
        if (cnt_q == CW'(1) || mplier_shifted == '0) state_d = S_RESULT_SET;
`else
        if (cnt_q == CW'(1)) state_d = S_RESULT_SET;
`endif
        else state_d = S_ADD;
      end
      S_RESULT_SET:   state_d = S_RESULT_VALID;
      S_RESULT_VALID: if (ack_i) state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d  = {{WIDTH{1'b0}}, a_i};
          mplier_d = b_i;
          acc_d    = '0;
          cnt_d    = CW'(N);
        end
      end
      S_ADD: acc_d = acc_q + mcand_q * step_digit;
      S_SHIFT: begin
        mcand_d  = mcand_q << STEP_BITS;
        mplier_d = mplier_shifted;
        cnt_d    = cnt_q - CW'(1);
      end
      S_RESULT_SET: product_d = acc_q;
      default: ;
    endcase
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_RESULT_VALID);
  end

  // NOTE: the datapath is cleared on reset too, so a reset mid-operation never leaks a partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_fpu_mul_iter.sv
// Randomised self-checking bench for fpu_mul_iter (24x24 step 1 and 8x8 step 4 instances).
module tb_fpu_mul_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start24, ack24, busy24, valid24;
  logic [23:0] a24, b24;
  logic [47:0] product24;
  logic        start8, ack8, busy8, valid8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int errors = 0;
  int checks = 0;

  fpu_mul_iter #(.WIDTH(24), .STEP_BITS(1)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .start_i(start24), .a_i(a24), .b_i(b24), .ack_i(ack24),
    .busy_o(busy24), .valid_o(valid24), .product_o(product24));

  fpu_mul_iter #(.WIDTH(8), .STEP_BITS(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8), .ack_i(ack8),
    .busy_o(busy8), .valid_o(valid8), .product_o(product8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycles from accept to valid: 2 per iteration plus setup and result transfer.
  function automatic int exp_lat(input logic [31:0] b, input int w, input int s);
    int n;
    n = w / s;
`ifdef FPU_MUL_EARLY_EXIT_EN
    begin
      int bl;
      bl = 0;
      for (int i = 0; i < w; i++) if (b[i]) bl = i + 1;
      n = (bl + s - 1) / s;
      if (n < 1) n = 1;
    end
`endif
    return 2 * n + 2;
  endfunction

  task automatic op24(input logic [23:0] a, input logic [23:0] b, input int hold,
                      input bit poke_start, input bit ack_with_start);
    logic [63:0] exp_p;
    logic [47:0] held;
    int lat, cyc, busy_low, unstable;
    exp_p = {40'b0, a} * {40'b0, b};
    lat = exp_lat({8'b0, b}, 24, 1);
    cyc = 0; busy_low = 0; unstable = 0;
    @(negedge clk);
    a24 = a; b24 = b; start24 = 1'b1;
    @(negedge clk);
    start24 = 1'b0; a24 = 24'($urandom); b24 = 24'($urandom);
    while (!valid24 && cyc < 300) begin
      if (!busy24) busy_low++;
      start24 = poke_start && (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start24 = 1'b0;
    check("lat24", 64'(cyc), 64'(lat));
    check("busy24_during_op", 64'(busy_low), 64'd0);
    check("product24", 64'(product24), exp_p);
    held = product24;
    repeat (hold) begin
      @(negedge clk);
      if (!valid24 || product24 !== held) unstable++;
    end
    if (hold > 0) check("hold24_stable", 64'(unstable), 64'd0);
    ack24 = 1'b1; start24 = ack_with_start;
    @(negedge clk);
    ack24 = 1'b0; start24 = 1'b0;
    check("ack24_idle", 64'({busy24, valid24}), 64'd0);
    check("product24_kept", 64'(product24), exp_p);
    if (ack_with_start) begin
      repeat (2) @(negedge clk);
      check("ack_start_not_captured", 64'(busy24), 64'd0);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    logic [63:0] exp_p;
    int lat, cyc;
    exp_p = {56'b0, a} * {56'b0, b};
    lat = exp_lat({24'b0, b}, 8, 4);
    cyc = 0;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (!valid8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("lat8", 64'(cyc), 64'(lat));
    check("product8", 64'(product8), exp_p);
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
    check("ack8_idle", 64'({busy8, valid8}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start24 = 1'b0; ack24 = 1'b0; a24 = '0; b24 = '0;
    start8  = 1'b0; ack8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    check("reset24_state", 64'({busy24, valid24, product24}), 64'd0);
    check("reset8_state", 64'({busy8, valid8, product8}), 64'd0);
    rst_n = 1'b1;

    op24(24'hC00000, 24'hA00000, 10, 1'b1, 1'b0);
    op24(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0, 1'b0);
    op24(24'h000000, 24'h5A5A5A, 0, 1'b0, 1'b1);
    op24(24'h123456, 24'h000000, 2, 1'b0, 1'b0);
    op8(8'hFF, 8'h0F);
    op8(8'hFF, 8'hFF);
    op24(24'h800000, 24'h000003, 3, 1'b0, 1'b0);

    // Reset in the middle of an operation, then a clean run.
    @(negedge clk);
    a24 = 24'h123456; b24 = 24'hABCDEF; start24 = 1'b1;
    @(negedge clk);
    start24 = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midop_reset", 64'({busy24, valid24, product24}), 64'd0);
    rst_n = 1'b1;
    op24(24'h123456, 24'hABCDEF, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [23:0] ra, rb;
      ra = 24'($urandom);
      rb = 24'($urandom) >> $urandom_range(0, 23);
      op24(ra, rb, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      op8(8'($urandom), 8'($urandom) >> $urandom_range(0, 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
